// File: rtl/btn_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btn_mode_ctrl
//  Description : Button-driven capture-mode scheduler for the OV7670 pipeline.
//                Debounces three raw buttons, sequences frame-buffer writes
//                (live / freeze / snapshot) on frame boundaries, and hands
//                sensor reconfiguration requests to the SCCB configurator
//                through a cfg_req/cfg_ack handshake.
//  Ports       : clk, rst (sync, active-high)
//                btn_freeze, btn_snap, btn_cfg : raw async buttons
//                frame_start : 1-cycle pulse at start of each sensor frame
//                cfg_ack     : configurator done (level)
//                cfg_req     : request configurator to load cfg_preset
//                cfg_preset  : preset index, stable while cfg_req=1
//                wr_en       : frame-buffer write enable
//                mode        : current state code
//                cfg_err     : sticky, last config request timed out
//  Options     : LONG_PRESS_EN - cfg fires on release (short press) or after
//                LONG_CYCLES of hold (long press, preset reset to 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_mode_ctrl #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int NUM_PRESETS = 4,
    parameter int CFG_TIMEOUT = 2_000_000,
    parameter int LONG_CYCLES = 100_000_000,
    localparam int PW = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_freeze,
    input  logic          btn_snap,
    input  logic          btn_cfg,
    input  logic          frame_start,
    input  logic          cfg_ack,
    output logic          cfg_req,
    output logic [PW-1:0] cfg_preset,
    output logic          wr_en,
    output logic [2:0]    mode,
    output logic          cfg_err
);

    localparam int c_DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int c_TO_W  = $clog2(CFG_TIMEOUT + 1);

    localparam logic [c_DEB_W-1:0] c_DEB_LAST    = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST     = c_TO_W'(CFG_TIMEOUT - 1);
    localparam logic [PW-1:0]      c_PRESET_LAST = PW'(NUM_PRESETS - 1);

    localparam logic [2:0] c_S_RESYNC    = 3'd0;
    localparam logic [2:0] c_S_LIVE      = 3'd1;
    localparam logic [2:0] c_S_FRZ_PEND  = 3'd2;
    localparam logic [2:0] c_S_FROZEN    = 3'd3;
    localparam logic [2:0] c_S_SNAP_WAIT = 3'd4;
    localparam logic [2:0] c_S_SNAP_CAP  = 3'd5;
    localparam logic [2:0] c_S_CFG_WAIT  = 3'd6;

    // Bit order: 0 = freeze, 1 = snap, 2 = cfg
    logic [2:0] w_btnRaw;
    logic [2:0] w_acc;
    logic [2:0] r_accD;
    logic [2:0] w_rise;

    assign w_btnRaw = {btn_cfg, btn_snap, btn_freeze};

    // ------------------------------------------------------------------
    // Synchroniser + counter debounce per button. The counter only runs
    // while the synchronised level disagrees with the accepted level, so
    // any bounce back to the accepted level restarts the qualification.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic               r_s1;
            logic               r_s2;
            logic               r_accLvl;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_accLvl <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1 <= w_btnRaw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_accLvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_accLvl <= r_s2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_acc[gi] = r_accLvl;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_accD <= 3'b000;
        end else begin
            r_accD <= w_acc;
        end
    end

    assign w_rise = w_acc & ~r_accD;

    // ------------------------------------------------------------------
    // cfg action generation
    // ------------------------------------------------------------------
    logic w_cfgAct;
    logic w_cfgToZero;

`ifdef LONG_PRESS_EN
    localparam int c_LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [c_LONG_W-1:0] c_LONG_LAST = c_LONG_W'(LONG_CYCLES - 1);

    logic [c_LONG_W-1:0] r_holdCnt;
    logic                r_longDone;
    logic                w_cfgFall;
    logic                w_longFire;

    assign w_cfgFall  = ~w_acc[2] & r_accD[2];
    assign w_longFire = w_acc[2] & ~w_rise[2] & ~r_longDone & (r_holdCnt == c_LONG_LAST);

    // Hold timer restarts on every accepted press; once the long action
    // has fired, r_longDone suppresses the action on the following release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_holdCnt  <= '0;
            r_longDone <= 1'b0;
        end else if (w_rise[2]) begin
            r_holdCnt  <= '0;
            r_longDone <= 1'b0;
        end else if (w_longFire) begin
            r_longDone <= 1'b1;
        end else if (w_acc[2] && !r_longDone) begin
            r_holdCnt <= r_holdCnt + 1'b1;
        end
    end

    assign w_cfgAct    = w_longFire | (w_cfgFall & ~r_longDone);
    assign w_cfgToZero = w_longFire;
`else
    assign w_cfgAct    = w_rise[2];
    assign w_cfgToZero = 1'b0;
`endif

    // Same-cycle priority: cfg > snap > freeze, losers are dropped.
    logic w_evtSnap;
    logic w_evtFrz;

    assign w_evtSnap = w_rise[1] & ~w_cfgAct;
    assign w_evtFrz  = w_rise[0] & ~w_rise[1] & ~w_cfgAct;

    // ------------------------------------------------------------------
    // Mode state machine
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [c_TO_W-1:0] r_toCnt;

    logic [2:0]        w_nextState;
    logic [c_TO_W-1:0] w_nextToCnt;
    logic [PW-1:0]     w_nextPreset;
    logic              w_nextReq;
    logic              w_nextErr;
    logic              w_nextWrEn;

    always_comb begin
        w_nextState  = r_state;
        w_nextToCnt  = r_toCnt;
        w_nextPreset = cfg_preset;
        w_nextReq    = cfg_req;
        w_nextErr    = cfg_err;

        if (r_state == c_S_CFG_WAIT) begin
            // Ack is checked first so an ack on the timeout cycle wins.
            if (cfg_ack) begin
                w_nextState = c_S_RESYNC;
                w_nextReq   = 1'b0;
                w_nextErr   = 1'b0;
            end else if (r_toCnt == c_TO_LAST) begin
                w_nextState = c_S_RESYNC;
                w_nextReq   = 1'b0;
                w_nextErr   = 1'b1;
            end else begin
                w_nextToCnt = r_toCnt + 1'b1;
            end
        end else if (w_cfgAct) begin
            if (w_cfgToZero || (cfg_preset == c_PRESET_LAST)) begin
                w_nextPreset = '0;
            end else begin
                w_nextPreset = cfg_preset + 1'b1;
            end
            w_nextReq   = 1'b1;
            w_nextToCnt = '0;
            w_nextState = c_S_CFG_WAIT;
        end else begin
            // An event ignored by the current state lets frame_start act.
            case (r_state)
                c_S_RESYNC: begin
                    if (frame_start) w_nextState = c_S_LIVE;
                end
                c_S_LIVE: begin
                    if (w_evtSnap)     w_nextState = c_S_SNAP_WAIT;
                    else if (w_evtFrz) w_nextState = c_S_FRZ_PEND;
                end
                c_S_FRZ_PEND: begin
                    if (w_evtFrz)         w_nextState = c_S_LIVE;
                    else if (frame_start) w_nextState = c_S_FROZEN;
                end
                c_S_FROZEN: begin
                    if (w_evtSnap)     w_nextState = c_S_SNAP_WAIT;
                    else if (w_evtFrz) w_nextState = c_S_RESYNC;
                end
                c_S_SNAP_WAIT: begin
                    if (frame_start) w_nextState = c_S_SNAP_CAP;
                end
                c_S_SNAP_CAP: begin
                    if (frame_start) w_nextState = c_S_FROZEN;
                end
                default: w_nextState = c_S_RESYNC;
            endcase
        end

        case (w_nextState)
            c_S_LIVE, c_S_FRZ_PEND, c_S_SNAP_CAP: w_nextWrEn = 1'b1;
            default:                              w_nextWrEn = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_RESYNC;
            r_toCnt    <= '0;
            cfg_preset <= '0;
            cfg_req    <= 1'b0;
            cfg_err    <= 1'b0;
            wr_en      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_toCnt    <= w_nextToCnt;
            cfg_preset <= w_nextPreset;
            cfg_req    <= w_nextReq;
            cfg_err    <= w_nextErr;
            wr_en      <= w_nextWrEn;
        end
    end

    assign mode = r_state;

endmodule
`default_nettype wire
